// File: rtl/infer_mac_pkg.sv
// Shared definitions for the inference MAC pipeline: mode encoding, product
// width derivation and the round-half-up / saturate helper.
package infer_mac_pkg;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_MAC = 1'b1;

    // Working width of the round/saturate helper; must exceed ACC_W+1.
    localparam int RS_W = 128;

    typedef struct packed {
        logic signed [RS_W-1:0] value;
        logic                   clamp;
    } rs_t;

    function automatic int prod_width(input int a_w, input int b_w);
        return a_w + b_w;
    endfunction

    // Sign-extended input, so the rounding add has headroom and cannot wrap.
    function automatic rs_t round_sat(input logic signed [RS_W-1:0] r,
                                      input int shift, input int out_w);
        logic signed [RS_W-1:0] half;
        logic signed [RS_W-1:0] rnd;
        logic signed [RS_W-1:0] hi;
        logic signed [RS_W-1:0] lo;
        rs_t res;
        if (shift > 0) begin
            half = RS_W'(1'b1) <<< (shift - 1);
        end else begin
            half = '0;
        end
        rnd = (r + half) >>> shift;
        hi  = (RS_W'(1'b1) <<< (out_w - 1)) - RS_W'(1'b1);
        lo  = ~hi;
        if (rnd > hi) begin
            res.value = hi;
            res.clamp = 1'b1;
        end else if (rnd < lo) begin
            res.value = lo;
            res.clamp = 1'b1;
        end else begin
            res.value = rnd;
            res.clamp = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/infer_mac_mul_pipe.sv
// Pipelined signed multiplier with a parallel valid/tag chain. Operands are
// registered once, then the product passes NUM_STAGE-2 registers.
module infer_mac_mul_pipe
    import infer_mac_pkg::*;
#(
    parameter int A_W       = 14,
    parameter int B_W       = 21,
    parameter int NUM_STAGE = 4,
    parameter int PROD_W    = prod_width(A_W, B_W)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     ce_i,
    input  logic                     valid_i,
    input  logic                     mode_i,
    input  logic                     first_i,
    input  logic                     last_i,
    input  logic signed [A_W-1:0]    a_i,
    input  logic signed [B_W-1:0]    b_i,
    output logic                     valid_o,
    output logic                     mode_o,
    output logic                     first_o,
    output logic                     last_o,
    output logic signed [PROD_W-1:0] prod_o
);

    localparam int PD = NUM_STAGE - 2;
    localparam int TD = NUM_STAGE - 1;

    logic signed [A_W-1:0]    a_q;
    logic signed [B_W-1:0]    b_q;
    logic signed [PROD_W-1:0] prod_q [PD];
    logic [TD-1:0]            vld_q;
    logic [TD-1:0]            mode_q;
    logic [TD-1:0]            first_q;
    logic [TD-1:0]            last_q;

    // Multiply into a bare register chain so synthesis can retime the trailing
    // product registers into the DSP block.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            a_q     <= '0;
            b_q     <= '0;
            vld_q   <= '0;
            mode_q  <= '0;
            first_q <= '0;
            last_q  <= '0;
            for (int i = 0; i < PD; i++) begin
                prod_q[i] <= '0;
            end
        end else if (ce_i) begin
            a_q       <= a_i;
            b_q       <= b_i;
            prod_q[0] <= PROD_W'(a_q) * PROD_W'(b_q);
            for (int i = 1; i < PD; i++) begin
                prod_q[i] <= prod_q[i-1];
            end
            vld_q   <= {vld_q[TD-2:0], valid_i};
            mode_q  <= {mode_q[TD-2:0], mode_i};
            first_q <= {first_q[TD-2:0], first_i};
            last_q  <= {last_q[TD-2:0], last_i};
        end
    end

    assign valid_o = vld_q[TD-1];
    assign mode_o  = mode_q[TD-1];
    assign first_o = first_q[TD-1];
    assign last_o  = last_q[TD-1];
    assign prod_o  = prod_q[PD-1];

endmodule

// File: rtl/infer_mac_pipe.sv
// Parametrised pipelined signed multiply / grouped multiply-accumulate with
// round-half-up, saturation and overflow reporting.
module infer_mac_pipe
    import infer_mac_pkg::*;
#(
    parameter int A_W       = 14,
    parameter int B_W       = 21,
    parameter int ACC_W     = 40,
    parameter int OUT_W     = 16,
    parameter int SHIFT     = 4,
    parameter int NUM_STAGE = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ce,
    input  logic                    in_valid,
    input  logic                    in_first,
    input  logic                    in_last,
    input  logic                    mode,
    input  logic signed [A_W-1:0]   din0,
    input  logic signed [B_W-1:0]   din1,
    output logic                    out_valid,
    output logic signed [OUT_W-1:0] dout,
    output logic                    ovf
);

    localparam int PROD_W = prod_width(A_W, B_W);

    logic                    m_valid_s;
    logic                    m_mode_s;
    logic                    m_first_s;
    logic                    m_last_s;
    logic signed [PROD_W-1:0] m_prod_s;

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    sticky_q, sticky_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [OUT_W-1:0] dout_q, dout_d;
    logic                    ovf_q, ovf_d;

    logic signed [ACC_W-1:0] p_ext_s;
    logic signed [ACC_W-1:0] sum_s;
    logic signed [ACC_W-1:0] r_s;
    logic                    add_ovf_s;
    logic                    grp_ovf_s;
    rs_t                     rs_s;
    logic                    unused_s;

    infer_mac_mul_pipe #(
        .A_W       (A_W),
        .B_W       (B_W),
        .NUM_STAGE (NUM_STAGE),
        .PROD_W    (PROD_W)
    ) u_mul (
        .clk_i   (clk),
        .reset_i (reset),
        .ce_i    (ce),
        .valid_i (in_valid),
        .mode_i  (mode),
        .first_i (in_first),
        .last_i  (in_last),
        .a_i     (din0),
        .b_i     (din1),
        .valid_o (m_valid_s),
        .mode_o  (m_mode_s),
        .first_o (m_first_s),
        .last_o  (m_last_s),
        .prod_o  (m_prod_s)
    );

    // Final stage: accumulate, then round/saturate the selected result.
    always_comb begin
        p_ext_s     = ACC_W'(m_prod_s);
        sum_s       = acc_q + p_ext_s;
        add_ovf_s   = (acc_q[ACC_W-1] == p_ext_s[ACC_W-1]) &&
                      (sum_s[ACC_W-1] != acc_q[ACC_W-1]);
        acc_d       = acc_q;
        sticky_d    = sticky_q;
        out_valid_d = 1'b0;
        r_s         = p_ext_s;
        grp_ovf_s   = 1'b0;
        if (m_valid_s) begin
            if (m_mode_s == MODE_MAC) begin
                if (m_first_s) begin
                    acc_d    = p_ext_s;
                    sticky_d = 1'b0;
                end else begin
                    acc_d    = sum_s;
                    sticky_d = sticky_q | add_ovf_s;
                end
                r_s         = acc_d;
                grp_ovf_s   = sticky_d;
                out_valid_d = m_last_s;
            end else begin
                r_s         = p_ext_s;
                grp_ovf_s   = 1'b0;
                out_valid_d = 1'b1;
            end
        end else begin
            out_valid_d = 1'b0;
        end
        rs_s = round_sat(RS_W'(r_s), SHIFT, OUT_W);
        if (out_valid_d) begin
            dout_d = rs_s.value[OUT_W-1:0];
            ovf_d  = rs_s.clamp | grp_ovf_s;
        end else begin
            dout_d = dout_q;
            ovf_d  = ovf_q;
        end
    end

    // The clamp already bounds the value, so upper bits carry no information.
    assign unused_s = ^rs_s.value[RS_W-1:OUT_W];

    // Accumulator, sticky flag and output registers; ce=0 freezes them all.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q       <= '0;
            sticky_q    <= 1'b0;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            ovf_q       <= 1'b0;
        end else if (ce) begin
            acc_q       <= acc_d;
            sticky_q    <= sticky_d;
            out_valid_q <= out_valid_d;
            dout_q      <= dout_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign dout      = dout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_infer_mac_pipe.sv
// Self-checking bench: directed cases pinned by literals, then random traffic,
// all compared every cycle against an arithmetic reference model.
module tb_infer_mac_pipe;

    localparam int A_W       = 14;
    localparam int B_W       = 21;
    localparam int ACC_W     = 40;
    localparam int OUT_W     = 16;
    localparam int SHIFT     = 4;
    localparam int NUM_STAGE = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             ce = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_first = 1'b0;
    logic             in_last = 1'b0;
    logic             mode = 1'b0;
    logic [A_W-1:0]   din0 = '0;
    logic [B_W-1:0]   din1 = '0;
    logic             out_valid;
    logic [OUT_W-1:0] dout;
    logic             ovf;

    always #5 clk = ~clk;

    infer_mac_pipe #(
        .A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .OUT_W(OUT_W),
        .SHIFT(SHIFT), .NUM_STAGE(NUM_STAGE)
    ) dut (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
        .in_first(in_first), .in_last(in_last), .mode(mode),
        .din0(din0), .din1(din1), .out_valid(out_valid), .dout(dout), .ovf(ovf)
    );

    typedef struct {
        int due;
        int dv;
        bit ov;
        bit lit;
        int ldv;
        bit lov;
    } exp_t;

    exp_t   exp_q[$];
    int     ce_cnt  = 0;
    int     n_cmp   = 0;
    int     n_bad   = 0;
    bit     chk_en  = 1'b0;
    longint m_acc   = 0;
    bit     m_sticky = 1'b0;
    int     hold_dv = 0;
    bit     hold_ov = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic longint wrap_acc(input longint v);
        longint t;
        t = v <<< (64 - ACC_W);
        return t >>> (64 - ACC_W);
    endfunction

    function automatic void rnd_sat(input longint r, output int dv, output bit ov);
        longint t;
        longint hi;
        longint lo;
        t  = (SHIFT > 0) ? r + (longint'(1) <<< (SHIFT - 1)) : r;
        t  = t >>> SHIFT;
        hi = (longint'(1) <<< (OUT_W - 1)) - 1;
        lo = -hi - 1;
        if (t > hi) begin
            dv = int'(hi); ov = 1'b1;
        end else if (t < lo) begin
            dv = int'(lo); ov = 1'b1;
        end else begin
            dv = int'(t); ov = 1'b0;
        end
    endfunction

    task automatic model_accept(input bit f, input bit l, input bit md, input int a, input int b,
                                input bit lit, input int ldv, input bit lov);
        longint p;
        longint s;
        longint r;
        bit     grp;
        bit     emit;
        int     dv;
        bit     ov;
        exp_t   e;
        p = longint'(a) * longint'(b);
        if (md == 1'b0) begin
            r = p; grp = 1'b0; emit = 1'b1;
        end else begin
            if (f) begin
                m_acc = p; m_sticky = 1'b0;
            end else begin
                s = m_acc + p;
                m_acc = wrap_acc(s);
                if (m_acc != s) m_sticky = 1'b1;
            end
            r = m_acc; grp = m_sticky; emit = l;
        end
        if (emit) begin
            rnd_sat(r, dv, ov);
            e.due = ce_cnt + NUM_STAGE - 1;
            e.dv  = dv;
            e.ov  = ov | grp;
            e.lit = lit;
            e.ldv = ldv;
            e.lov = lov;
            exp_q.push_back(e);
        end
    endtask

    task automatic step(input bit c, input bit v, input bit f, input bit l, input bit md,
                        input int a, input int b,
                        input bit lit = 1'b0, input int ldv = 0, input bit lov = 1'b0);
        ce = c; in_valid = v; in_first = f; in_last = l; mode = md;
        din0 = a[A_W-1:0];
        din1 = b[B_W-1:0];
        @(posedge clk);
        if (reset) begin
            exp_q.delete();
            m_acc = 0; m_sticky = 1'b0; hold_dv = 0; hold_ov = 1'b0;
        end else if (c) begin
            ce_cnt++;
            if (v) model_accept(f, l, md, a, b, lit, ldv, lov);
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    // Compare DUT outputs against the model on every cycle, away from the clock edge.
    always @(negedge clk) begin
        if (chk_en) begin
            while (exp_q.size() > 0 && exp_q[0].due < ce_cnt) begin
                hold_dv = exp_q[0].dv;
                hold_ov = exp_q[0].ov;
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].due == ce_cnt) begin
                check("out_valid_hi", longint'(out_valid), 1);
                check("dout", longint'($signed(dout)), exp_q[0].dv);
                check("ovf", longint'(ovf), longint'(exp_q[0].ov));
                if (exp_q[0].lit) begin
                    check("model_dout_pin", exp_q[0].dv, exp_q[0].ldv);
                    check("model_ovf_pin", longint'(exp_q[0].ov), longint'(exp_q[0].lov));
                    check("dout_literal", longint'($signed(dout)), exp_q[0].ldv);
                    exp_q[0].lit = 1'b0;
                end
            end else begin
                check("out_valid_lo", longint'(out_valid), 0);
                check("dout_hold", longint'($signed(dout)), hold_dv);
                check("ovf_hold", longint'(ovf), longint'(hold_ov));
            end
        end
    end

    initial begin
        bit c, v, f, l, md;
        int a, b;
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        chk_en = 1'b1;

        // 1: plain multiply with rounding of a negative product
        step(1, 1, 0, 0, 0, 3, -5, 1, -1, 0);
        idle(6);
        // 2: most-positive product saturates
        step(1, 1, 0, 0, 0, -8192, -1048576, 1, 32767, 1);
        idle(6);
        // 3: four-element group
        step(1, 1, 1, 0, 1, 100, 16);
        step(1, 1, 0, 0, 1, 100, 16);
        step(1, 1, 0, 0, 1, 100, 16);
        step(1, 1, 0, 1, 1, 100, 16, 1, 400, 0);
        idle(6);
        // 4: same group with a three-cycle ce stall
        step(1, 1, 1, 0, 1, 100, 16);
        step(1, 1, 0, 0, 1, 100, 16);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 1, 100, 16);
        step(1, 1, 0, 1, 1, 100, 16, 1, 400, 0);
        idle(6);
        // 5: reset aborts a partial group
        step(1, 1, 1, 0, 1, 1000, 1000);
        step(1, 1, 0, 0, 1, 1000, 1000);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        step(1, 1, 1, 1, 1, 1, 16, 1, 1, 0);
        idle(6);
        // 6: mixed modes back-to-back
        step(1, 1, 1, 0, 1, 16, 16);
        step(1, 1, 0, 1, 1, 16, 16, 1, 32, 0);
        step(1, 1, 0, 0, 0, 32, 1, 1, 2, 0);
        step(1, 1, 1, 1, 1, -16, 1, 1, -1, 0);
        idle(6);
        // out_valid held high across a ce stall
        step(1, 1, 1, 1, 1, 5, 16, 1, 5, 0);
        idle(3);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0);
        idle(4);
        // accumulator wraps back to exactly zero: only the sticky flag reports it
        step(1, 1, 1, 0, 1, -8192, -1048576);
        for (int i = 0; i < 126; i++) step(1, 1, 0, 0, 1, -8192, -1048576);
        step(1, 1, 0, 1, 1, -8192, -1048576, 1, 0, 1);
        step(1, 1, 1, 1, 1, 1, 16, 1, 1, 0);
        idle(6);

        // randomized traffic with stalls, mixed modes and occasional reset
        for (int i = 0; i < 4000; i++) begin
            c  = ($urandom_range(0, 99) < 85);
            v  = ($urandom_range(0, 99) < 75);
            f  = ($urandom_range(0, 3) == 0);
            l  = ($urandom_range(0, 3) == 0);
            md = $urandom_range(0, 1) == 1;
            a  = int'($urandom_range(0, (1 << A_W) - 1)) - (1 << (A_W - 1));
            b  = int'($urandom_range(0, (1 << B_W) - 1)) - (1 << (B_W - 1));
            reset = ($urandom_range(0, 299) == 0);
            step(c, v, f, l, md, a, b);
            reset = 1'b0;
        end
        idle(NUM_STAGE + 4);
        check("drain_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/infer_mac_pipe.md
Name: infer_mac_pipe

Overview:
- Parametrised successor to the fixed-width pipelined signed multipliers (e.g. 14s x 21s -> 35).
- Configurable operand widths, pipeline depth, multiply-only or grouped multiply-accumulate mode, valid tracking, round-half-up, and saturation to the output width.
- Sits in the inference datapath; feeds dot-product and scaling stages that need a single fixed-point result per vector.

Parameters:
- A_W, 14, signed width of din0
- B_W, 21, signed width of din1
- ACC_W, 40, accumulator width; must be >= A_W+B_W
- OUT_W, 16, signed width of dout
- SHIFT, 4, right shift applied before output; 0..ACC_W-1
- NUM_STAGE, 4, accepted-input-to-output latency in ce cycles; >= 3

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ce  in  1  clock enable; 0 freezes all state
- in_valid  in  1  din0/din1 and tags valid this cycle
- in_first  in  1  element starts an accumulation group (mode 1 only)
- in_last  in  1  element ends the group; result is emitted (mode 1 only)
- mode  in  1  0 = multiply only, 1 = accumulate
- din0  in  A_W  signed operand
- din1  in  B_W  signed operand
- out_valid  out  1  dout/ovf valid, one-cycle pulse per result
- dout  out  OUT_W  rounded, saturated result
- ovf  out  1  saturation or accumulator overflow occurred for this result

Behaviour:
- Single clock domain. Reset is synchronous and active-high. Ports are named clk and reset.
- Reset clears every valid bit, the accumulator, and the sticky overflow bit. Outputs after reset: out_valid=0, dout=0, ovf=0.
- Reset mid-group discards all in-flight elements and the partial sum. No output is produced for the aborted group.
- Input is accepted when ce=1 and in_valid=1. There is no backpressure.
- mode, in_first and in_last are sampled with the operands and travel in the valid pipeline.
- ce=0: all registers hold, including out_valid. A pulse that is high stays high until the next ce=1 cycle.
- Pipeline structure:
  - Stage 1: registers operands and tags.
  - Stages 2..NUM_STAGE-1: product P = din0*din1, PROD_W = A_W+B_W bits, exact.
  - Stage NUM_STAGE: accumulate/round/saturate into the output registers.
- Mode 0:
  - R = sign-extend(P) to ACC_W.
  - out_valid pulses exactly NUM_STAGE ce-cycles after acceptance.
  - The accumulator is untouched.
- Mode 1:
  - If first: acc <= P, ovf_sticky <= 0. Otherwise: acc <= acc + P.
  - If the signed ACC_W add overflows: acc wraps (two's complement) and ovf_sticky <= 1.
  - An element without a preceding first continues the existing acc.
  - first and last in the same element form a single-element group.
  - out_valid pulses only for the last element, NUM_STAGE ce-cycles after it was accepted. R is the updated acc.
- Output arithmetic:
  - Compute (R + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT, using ACC_W+1 bits internally so the rounding add cannot overflow.
  - Clamp the result to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - ovf = clamp occurred OR ovf_sticky (mode 1).
- dout and ovf hold their last values while out_valid=0.
- Mixed modes are allowed back-to-back, with one output per cycle.

Decomposition:
- Package infer_mac_pkg:
  - PROD_W derivation
  - round/saturate function (ACC_W+1 -> OUT_W, with clamp flag)
  - mode encoding constants MODE_MUL=0, MODE_MAC=1
- Sub-module infer_mac_mul_pipe:
  - signed multiplier, operand registers, NUM_STAGE-2 product registers, with a parallel tag/valid shift chain, all gated by ce
  - retiming-friendly so the multiply infers DSP.
- The top level holds the accumulator, the sticky flag and the output stage.

Test Plan (defaults: A_W=14, B_W=21, ACC_W=40, OUT_W=16, SHIFT=4, NUM_STAGE=4):
1. Mode 0, din0=3, din1=-5 (P=-15) -> out_valid 4 cycles later, dout=-1 ((-15+8)>>>4), ovf=0; no other out_valid pulse.
2. Mode 0, din0=-8192, din1=-1048576 (P=2^33) -> dout=32767, ovf=1.
3. Mode 1, four elements (100,16) with first on element 0 and last on element 3 -> single out_valid 4 cycles after the last, dout=400 (6400>>4), ovf=0.
4. Repeat test 3 with ce=0 for 3 cycles after the second element -> out_valid delayed by exactly 3 cycles, dout=400; out_valid held while ce=0 if it was high.
5. Mode 1: start a group with (1000,1000) x2, assert reset 1 cycle, then send (1,16) with first+last -> exactly one out_valid, dout=1, ovf=0.
6. Back-to-back: group {first (16,16), last (16,16)} then mode 0 (32,1) then single-element group (-16,1) -> dout sequence 32, 2, -1 on consecutive valid outputs; ovf=0 for all three.
